// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART register-access command responder:
// frame sync bytes, command and status codes, and the FSM state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] RSYNC_BYTE = 8'h5A;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BAD_CHK = 8'h01;
  localparam logic [7:0] STATUS_BAD_CMD = 8'h02;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_BUS  = 3'd5,
    ST_RESP = 3'd6
  } state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter; expired_c pulses on an enabled cycle once the count
// has run down to zero.
module uart_cmd_timeout #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired_c
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired_c = en && !load && (count_q == '0);

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses register read/write frames from the UART RX buffer, runs them on the
// register bus and streams a response frame into the UART TX buffer.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BITLEN       = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ACK_TIMEOUT  = 1024,
  parameter int unsigned IDLE_TIMEOUT = 100_000
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [BITLEN-1:0]     rx_data,
  input  logic                  rx_empty,
  output logic                  rx_read,
  output logic [BITLEN-1:0]     tx_data,
  output logic                  tx_write,
  input  logic                  tx_full,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  output logic                  busy
);

  localparam int unsigned DATA_BYTES = DATA_WIDTH / BITLEN;
  localparam int unsigned RESP_BYTES = DATA_BYTES + 3;
  localparam int unsigned RESP_W     = RESP_BYTES * BITLEN;
  localparam int unsigned CNT_W      = $clog2(DATA_BYTES + 1);
  localparam int unsigned LEN_W      = $clog2(RESP_BYTES + 1);
  localparam int unsigned IDLE_W     = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned ACK_W      = $clog2(ACK_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [BITLEN-1:0]     chk_q, chk_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [RESP_W-1:0]     resp_q, resp_d;
  logic [LEN_W-1:0]      left_q, left_d;
  logic                  run_q;

  logic                  rx_state_c;
  logic                  frame_state_c;
  logic                  idle_en_c;
  logic                  idle_exp_c;
  logic                  ack_load_c;
  logic                  ack_en_c;
  logic                  ack_exp_c;
  logic [BITLEN-1:0]     rdata_xor_c;

  // Error and write-OK responses: sync, status, status as checksum
  function automatic logic [RESP_W-1:0] short_resp(input logic [7:0] status);
    return {RSYNC_BYTE, status, status, {(RESP_W - 24){1'b0}}};
  endfunction

  always_comb begin
    rdata_xor_c = STATUS_OK;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rdata_xor_c = rdata_xor_c ^ reg_rdata[i*BITLEN +: BITLEN];
    end
  end

  assign rx_state_c    = (state_q == ST_IDLE) || (state_q == ST_CMD) ||
                         (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                         (state_q == ST_CHK);
  assign frame_state_c = rx_state_c && (state_q != ST_IDLE);

  uart_cmd_timeout #(.WIDTH(IDLE_W)) u_idle_timeout (
    .clk        (clk),
    .rstb       (rstb),
    .load       (rx_read),
    .load_value (IDLE_W'(IDLE_TIMEOUT - 1)),
    .en         (idle_en_c),
    .expired_c  (idle_exp_c)
  );

  uart_cmd_timeout #(.WIDTH(ACK_W)) u_ack_timeout (
    .clk        (clk),
    .rstb       (rstb),
    .load       (ack_load_c),
    .load_value (ACK_W'(ACK_TIMEOUT)),
    .en         (ack_en_c),
    .expired_c  (ack_exp_c)
  );

  // State and datapath registers; run_q keeps rx_read low while reset is held
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      chk_q      <= '0;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      resp_q     <= '0;
      left_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      resp_q     <= resp_d;
      left_q     <= left_d;
      run_q      <= 1'b1;
    end
  end

  // Parser, bus sequencer and response serializer
  always_comb begin
    state_d    = state_q;
    chk_d      = chk_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    resp_d     = resp_q;
    left_d     = left_q;
    rx_read    = 1'b0;
    tx_write   = 1'b0;
    idle_en_c  = 1'b0;
    ack_load_c = 1'b0;
    ack_en_c   = 1'b0;

    if (run_q && rx_state_c && !rx_empty) begin
      rx_read = 1'b1;
    end
    if (frame_state_c && rx_empty) begin
      idle_en_c = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_read && (rx_data == SYNC_BYTE)) begin
          state_d = ST_CMD;
          chk_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_CMD: begin
        if (rx_read) begin
          chk_d = chk_q ^ rx_data;
          if (rx_data == CMD_WRITE) begin
            is_write_d = 1'b1;
            state_d    = ST_ADDR;
          end else if (rx_data == CMD_READ) begin
            is_write_d = 1'b0;
            state_d    = ST_ADDR;
          end else begin
            resp_d  = short_resp(STATUS_BAD_CMD);
            left_d  = LEN_W'(3);
            state_d = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (rx_read) begin
          chk_d   = chk_q ^ rx_data;
          addr_d  = ADDR_WIDTH'(rx_data);
          state_d = is_write_q ? ST_DATA : ST_CHK;
        end
      end
      ST_DATA: begin
        if (rx_read) begin
          chk_d   = chk_q ^ rx_data;
          wdata_d = {wdata_q[DATA_WIDTH-BITLEN-1:0], rx_data};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (rx_read) begin
          if (rx_data == chk_q) begin
            wr_d       = is_write_q;
            rd_d       = !is_write_q;
            ack_load_c = 1'b1;
            state_d    = ST_BUS;
          end else begin
            resp_d  = short_resp(STATUS_BAD_CHK);
            left_d  = LEN_W'(3);
            state_d = ST_RESP;
          end
        end
      end
      ST_BUS: begin
        ack_en_c = 1'b1;
        if (reg_ack) begin
          if (is_write_q) begin
            resp_d = short_resp(STATUS_OK);
            left_d = LEN_W'(3);
          end else begin
            resp_d = {RSYNC_BYTE, STATUS_OK, reg_rdata, rdata_xor_c};
            left_d = LEN_W'(RESP_BYTES);
          end
          state_d = ST_RESP;
        end else if (ack_exp_c) begin
          resp_d  = short_resp(STATUS_TIMEOUT);
          left_d  = LEN_W'(3);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!tx_full) begin
          tx_write = 1'b1;
          resp_d   = {resp_q[RESP_W-BITLEN-1:0], {BITLEN{1'b0}}};
          left_d   = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abandon a stalled frame silently
    if (idle_exp_c) begin
      state_d = ST_IDLE;
    end
  end

  assign tx_data   = resp_q[RESP_W-1 -: BITLEN];
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench: RX/TX buffer models, a bus responder and a frame-level
// reference model feeding expected responses to decoupled monitors.
module tb_uart_cmd_responder;

  localparam int unsigned ACK_TO  = 40;
  localparam int unsigned IDLE_TO = 300;
  localparam int unsigned CLK_NS  = 10;

  typedef struct {
    logic        is_write;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rx_read;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_full;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        busy;

  logic [7:0]  rx_buf[$];
  logic [7:0]  exp_tx[$];
  bus_exp_t    exp_bus[$];
  int          ack_q[$];
  logic [31:0] rdata_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int strobe_cyc = 0;
  int pop_to_strobe = 0;
  int first_tx_cyc = 0;
  int tx_total = 0;
  bit tx_after_strobe = 1'b1;
  bit bp_mode = 1'b0;
  bit ack_busy = 1'b0;

  always #(CLK_NS/2) clk = ~clk;

  uart_cmd_responder #(
    .BITLEN(8), .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .ACK_TIMEOUT(ACK_TO), .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .clk(clk), .rstb(rstb),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RX buffer and TX-full source: inputs change 1ns after the rising edge
  initial begin
    bit popped;
    int pop_c;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    tx_full  = 1'b0;
    forever begin
      @(negedge clk);
      popped = rx_read;
      pop_c  = cyc;
      if (popped && rx_empty) fail_event("rx_read_while_empty");
      @(posedge clk);
      #1;
      if (popped && rx_buf.size() != 0) begin
        void'(rx_buf.pop_front());
        last_pop_cyc = pop_c;
      end
      rx_empty = (rx_buf.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rx_buf[0];
      tx_full  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // TX monitor
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (tx_write) begin
      tx_total++;
      check("tx_write_while_full", 64'(tx_full), 64'd0);
      check("rx_tx_same_cycle", 64'(rx_read), 64'd0);
      if (!tx_after_strobe) begin
        first_tx_cyc    = cyc;
        tx_after_strobe = 1'b1;
      end
      if (exp_tx.size() == 0) begin
        fail_event("tx_unexpected_byte");
      end else begin
        e = exp_tx.pop_front();
        check("tx_byte", 64'(tx_data), 64'(e));
      end
    end
  end

  // Bus strobe monitor
  initial forever begin
    bus_exp_t e;
    @(negedge clk);
    if (reg_wr || reg_rd) begin
      strobe_cyc      = cyc;
      pop_to_strobe   = cyc - last_pop_cyc;
      tx_after_strobe = 1'b0;
      check("strobe_exclusive", 64'(reg_wr && reg_rd), 64'd0);
      if (exp_bus.size() == 0) begin
        fail_event("bus_unexpected_strobe");
      end else begin
        e = exp_bus.pop_front();
        check("bus_is_write", 64'(reg_wr), 64'(e.is_write));
        check("bus_addr", 64'(reg_addr), 64'(e.addr));
        if (e.is_write) check("bus_wdata", 64'(reg_wdata), 64'(e.wdata));
      end
    end
  end

  // Register slave: acks after a per-transaction delay
  initial begin
    int d;
    logic [31:0] rd;
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if ((reg_wr || reg_rd) && ack_q.size() != 0) begin
        ack_busy = 1'b1;
        d  = ack_q.pop_front();
        rd = rdata_q.pop_front();
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
        end
        reg_rdata = rd;
        reg_ack   = 1'b1;
        @(posedge clk);
        #1;
        reg_ack   = 1'b0;
        reg_rdata = $urandom;
        ack_busy  = 1'b0;
      end
    end
  end

  // Reference model: expected response bytes for a frame outcome
  task automatic expect_resp(input logic [7:0] st, input bit with_data, input logic [31:0] d);
    logic [7:0] x;
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(st);
    x = st;
    if (with_data) begin
      for (int i = 3; i >= 0; i--) begin
        exp_tx.push_back(d[i*8 +: 8]);
        x = x ^ d[i*8 +: 8];
      end
    end
    exp_tx.push_back(x);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (rx_buf.size() == 0 && exp_tx.size() == 0 && exp_bus.size() == 0 &&
          !busy && !ack_busy) done = 1'b1;
    end
    if (!done) fail_event("wait_idle_timeout");
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                       input logic [7:0] chk_mask, input int ack_d, input logic [31:0] rdata,
                       input bit wait_done);
    logic [7:0] chk;
    bus_exp_t   be;
    bit is_w, is_r;
    is_w = (cmd == 8'h01);
    is_r = (cmd == 8'h02);
    rx_buf.push_back(8'hA5);
    rx_buf.push_back(cmd);
    if (!is_w && !is_r) begin
      expect_resp(8'h02, 1'b0, 32'h0);
    end else begin
      rx_buf.push_back(addr);
      chk = cmd ^ addr;
      if (is_w) begin
        for (int i = 3; i >= 0; i--) begin
          rx_buf.push_back(data[i*8 +: 8]);
          chk = chk ^ data[i*8 +: 8];
        end
      end
      rx_buf.push_back(chk ^ chk_mask);
      if (chk_mask != 8'h00) begin
        expect_resp(8'h01, 1'b0, 32'h0);
      end else begin
        be.is_write = is_w;
        be.addr     = addr;
        be.wdata    = data;
        exp_bus.push_back(be);
        ack_q.push_back(ack_d);
        rdata_q.push_back(rdata);
        if (ack_d > int'(ACK_TO)) expect_resp(8'h03, 1'b0, 32'h0);
        else if (is_w)            expect_resp(8'h00, 1'b0, 32'h0);
        else                      expect_resp(8'h00, 1'b1, rdata);
      end
    end
    if (wait_done) wait_idle();
  endtask

  task automatic random_frame();
    int k;
    logic [7:0] cmd;
    logic [7:0] g;
    repeat ($urandom_range(0, 2)) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h3C;
      rx_buf.push_back(g);
    end
    k = $urandom_range(0, 9);
    if (k <= 3)      cmd = 8'h01;
    else if (k <= 7) cmd = 8'h02;
    else if (k == 8) cmd = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02;
    else begin
      cmd = 8'($urandom);
      if (cmd == 8'h01 || cmd == 8'h02) cmd = 8'h80;
    end
    issue(cmd, 8'($urandom), $urandom,
          (k == 8) ? 8'($urandom_range(1, 255)) : 8'h00,
          ($urandom_range(0, 14) == 0) ? int'(ACK_TO) + 4 : int'($urandom_range(0, 5)),
          $urandom, 1'b1);
  endtask

  initial begin
    #(CLK_NS * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit hit;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_write", 64'(tx_write), 64'd0);
    check("reset_rx_read", 64'(rx_read), 64'd0);
    check("reset_strobes", 64'({reg_wr, reg_rd}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_tx_data", 64'(tx_data), 64'd0);
    check("reset_addr_wdata", {24'd0, reg_addr, reg_wdata}, 64'd0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Write frame, ack one cycle after the strobe
    issue(8'h01, 8'h10, 32'hDEADBEEF, 8'h00, 1, 32'h0, 1'b1);
    check("write_pop_to_strobe", 64'(pop_to_strobe), 64'd1);

    // Read frame, ack in the strobe cycle
    issue(8'h02, 8'h10, 32'h0, 8'h00, 0, 32'h12345678, 1'b1);
    check("read_pop_to_strobe", 64'(pop_to_strobe), 64'd1);
    check("read_strobe_to_tx", 64'(first_tx_cyc - strobe_cyc), 64'd1);

    // Bad checksum: sends 00 instead of 33
    issue(8'h01, 8'h10, 32'hDEADBEEF, 8'h33, 0, 32'h0, 1'b1);

    // Bus timeout with a late ack
    issue(8'h02, 8'h44, 32'h0, 8'h00, int'(ACK_TO) + 4, 32'hCAFEF00D, 1'b1);
    check("timeout_strobe_to_tx", 64'(first_tx_cyc - strobe_cyc), 64'(ACK_TO + 1));

    // Bad command
    issue(8'h7E, 8'h00, 32'h0, 8'h00, 0, 32'h0, 1'b1);

    // Garbage, partial frame, silence, then a valid read
    rx_buf.push_back(8'h00);
    rx_buf.push_back(8'hFF);
    rx_buf.push_back(8'hA5);
    rx_buf.push_back(8'h01);
    repeat (20) @(negedge clk);
    check("partial_frame_busy", 64'(busy), 64'd1);
    repeat (IDLE_TO - 30) @(negedge clk);
    check("partial_frame_still_busy", 64'(busy), 64'd1);
    repeat (40) @(negedge clk);
    check("partial_frame_abandoned", 64'(busy), 64'd0);
    issue(8'h02, 8'h21, 32'h0, 8'h00, 2, 32'h0BADF00D, 1'b1);

    // Backpressure on TX
    bp_mode = 1'b1;
    issue(8'h02, 8'h10, 32'h0, 8'h00, 0, 32'h12345678, 1'b1);
    repeat (8) random_frame();
    bp_mode = 1'b0;
    @(negedge clk);

    repeat (40) random_frame();

    // Reset after the third response byte
    base = tx_total;
    hit  = 1'b0;
    issue(8'h02, 8'h55, 32'h0, 8'h00, 0, 32'hA1B2C3D4, 1'b0);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (tx_total - base >= 3) hit = 1'b1;
    end
    if (!hit) fail_event("reset_test_no_tx");
    rstb = 1'b0;
    exp_tx.delete();
    rx_buf.push_back(8'h00);
    @(negedge clk);
    check("midreset_tx_write", 64'(tx_write), 64'd0);
    check("midreset_rx_read", 64'(rx_read), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_tx_data", 64'(tx_data), 64'd0);
    check("midreset_bus", {22'd0, reg_wr, reg_rd, reg_addr, reg_wdata}, 64'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (30) @(negedge clk);
    check("after_reset_rx_drained", 64'(rx_buf.size()), 64'd0);
    check("after_reset_busy", 64'(busy), 64'd0);
    check("after_reset_tx_count", 64'(tx_total - base), 64'd3);

    check("exp_tx_drained", 64'(exp_tx.size()), 64'd0);
    check("exp_bus_drained", 64'(exp_bus.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Frame-level command responder on the far side of the buffered UART, opposite the serial line. Pops received bytes from the UART RX buffer, parses register read/write frames, and executes them on a single-master register bus. Pushes a response frame into the UART TX buffer. Turns the UART byte pipe into host access to the FPGA control registers.

## Interface
- `BITLEN`, 8: UART byte width. Must be 8.
- `ADDR_WIDTH`, 8: register address width. Carried as one frame byte.
- `DATA_WIDTH`, 32: register data width. Four frame bytes, MSB first.
- `ACK_TIMEOUT`, 1024: cycles to wait for `reg_ack` before reporting timeout.
- `IDLE_TIMEOUT`, 100_000: cycles of RX silence inside a frame before the frame is abandoned.

Ports:
- `clk` in 1: the single clock.
- `rstb` in 1: asynchronous, active-low reset.
- `rx_data` in BITLEN: head byte of the RX buffer. Valid while `rx_empty`=0.
- `rx_empty` in 1: RX buffer empty.
- `rx_read` out 1: one-cycle pop of the RX head.
- `tx_data` out BITLEN: byte to push.
- `tx_write` out 1: one-cycle push into the TX buffer.
- `tx_full` in 1: TX buffer full.
- `reg_addr` out ADDR_WIDTH: bus address.
- `reg_wdata` out DATA_WIDTH: bus write data.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rd` out 1: one-cycle read strobe.
- `reg_rdata` in DATA_WIDTH: read data. Sampled when `reg_ack`=1.
- `reg_ack` in 1: transaction complete.
- `busy` out 1: high in every state except IDLE.

## Operation
- Request frame: SYNC `0xA5`, CMD, ADDR, DATA[4] (write only), CHK.
  - CMD `0x01` is write; CMD `0x02` is read.
  - CHK is the XOR of CMD, ADDR and DATA bytes.
- Response frame: `0x5A`, STATUS, RDATA[4] (read with STATUS=0 only), RCHK.
  - RCHK is the XOR of STATUS and RDATA bytes.
- STATUS codes: `0x00` OK, `0x01` bad checksum, `0x02` bad command, `0x03` bus timeout.
- FSM states and transitions:
  - IDLE: pops bytes and discards every byte that is not `0xA5`. On `0xA5` -> CMD.
  - CMD: a valid CMD -> ADDR. Any other CMD -> RESP with STATUS `0x02`, and the rest of the frame is not consumed.
  - ADDR: -> DATA for a write, -> CHK for a read.
  - DATA: 4 bytes, then -> CHK.
  - CHK: mismatch -> RESP with `0x01` and no bus access. Match -> BUS.
  - BUS: one strobe, then wait for `reg_ack` or timeout, then -> RESP.
  - RESP: emits the response bytes, then -> IDLE.
- The running XOR and the byte counter clear on entry to CMD.
- IDLE_TIMEOUT: in CMD/ADDR/DATA/CHK, RX empty for IDLE_TIMEOUT consecutive cycles -> IDLE. No response is sent. The counter reloads on every pop.
- A read returning STATUS `0x00` latches `reg_rdata` on `reg_ack`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters and latches cleared.
- RX consumption:
  - `rx_read` asserts only when `rx_empty`=0 and the FSM is in a receive state.
  - The byte on `rx_data` is consumed in that same cycle.
  - At most one pop per cycle.
- TX emission:
  - `tx_write` asserts only when `tx_full`=0, one byte per cycle.
  - While `tx_full`=1 the FSM holds RESP with `tx_data` stable, and no byte is dropped.
- Bus strobes:
  - `reg_wr`/`reg_rd` pulse exactly one cycle, in the first BUS cycle.
  - `reg_addr` and `reg_wdata` are stable from the strobe until BUS exits.
  - `reg_ack` is honoured in the strobe cycle or later.
  - With no ack within ACK_TIMEOUT cycles after the strobe, STATUS=`0x03`.
  - An ack arriving after BUS has exited is ignored.
- Latency with an empty TX buffer and ack in the strobe cycle:
  - Last CHK pop -> strobe: 1 cycle.
  - Strobe -> first `tx_write`: 1 cycle.
  - The response then streams back-to-back.
- `rx_read` and `tx_write` are never high in the same cycle. The FSM does not read RX during RESP.
- Reset mid-frame or mid-response: immediate return to IDLE. A partial response is not resumed, and no strobe is issued after reset.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the SYNC/RSYNC bytes `0xA5`/`0x5A`;
  - the CMD codes;
  - the STATUS codes;
  - the FSM state encoding.
- One sub-module is natural: `uart_cmd_timeout`, a loadable down-counter with an expiry flag. It is instantiated twice, once for IDLE_TIMEOUT and once for ACK_TIMEOUT.
- The parser, bus sequencer and response serializer stay in one FSM.

## Test plan
- Write frame:
  - Stimulus: A5 01 10 DE AD BE EF 33, ack one cycle after strobe.
  - Expect: one `reg_wr` with addr `0x10`, wdata `0xDEADBEEF`; TX bytes 5A 00 00.
- Read frame:
  - Stimulus: A5 02 10 12, `reg_rdata`=`0x12345678`.
  - Expect: one `reg_rd`; TX bytes 5A 00 12 34 56 78 08.
- Bad checksum:
  - Stimulus: A5 01 10 DE AD BE EF 00.
  - Expect: no strobe; TX bytes 5A 01 01.
- Bus timeout:
  - Stimulus: read frame, `reg_ack` held 0.
  - Expect: TX bytes 5A 03 03, starting ACK_TIMEOUT+1 cycles after strobe. A late ack is ignored.
- Resync and idle timeout:
  - Stimulus: 00 FF, then A5 01, then silence for IDLE_TIMEOUT cycles, then a valid read frame.
  - Expect: no response to the garbage or the partial frame; a correct response to the read frame.
- Backpressure and reset:
  - Stimulus: read frame with `tx_full` toggling.
  - Expect: 7 bytes in order, none duplicated.
  - Stimulus: `rstb` pulsed after the 3rd byte.
  - Expect: outputs 0, no further writes.
